// File: rtl/btn_debounce_rpt.sv
// N-button debouncer sampled on a tick strobe, with registered press/release
// pulses and per-button auto-repeat of the press pulse while a key is held.
module btn_debounce_rpt #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    localparam int CNT_W  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(STABLE_TICKS - 1);
    localparam logic [RC_W-1:0]  DELAY_TC = RC_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RC_W-1:0]  RATE_TC  = RC_W'(REPEAT_RATE - 1);
    localparam logic             RPT_EN   = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic             r_level;
            logic             w_level_next;
            logic             r_press;
            logic             w_press_next;
            logic             r_release;
            logic             w_release_next;
            logic [RC_W-1:0]  r_rc;
            logic [RC_W-1:0]  w_rc_next;
            rpt_state_t       r_state;
            rpt_state_t       w_state_next;
            logic             w_acc_press;
            logic             w_acc_release;
            logic             w_rpt_fire;

            // A sample that agrees with the current level restarts qualification.
            always_comb begin
                w_cnt_next    = r_cnt;
                w_level_next  = r_level;
                w_acc_press   = 1'b0;
                w_acc_release = 1'b0;
                if (tick) begin
                    if (r_sync2[gi] == r_level) begin
                        w_cnt_next = '0;
                    end else if (r_cnt == CNT_TC) begin
                        w_level_next  = r_sync2[gi];
                        w_cnt_next    = '0;
                        w_acc_press   = r_sync2[gi];
                        w_acc_release = ~r_sync2[gi];
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_rc_next    = r_rc;
                w_rpt_fire   = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_acc_press && RPT_EN) begin
                            w_state_next = ST_DELAY;
                            w_rc_next    = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (tick) begin
                            if (r_rc == DELAY_TC) begin
                                w_rpt_fire   = 1'b1;
                                w_rc_next    = '0;
                                w_state_next = ST_REPEAT;
                            end else begin
                                w_rc_next = r_rc + 1'b1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (tick) begin
                            if (r_rc == RATE_TC) begin
                                w_rpt_fire = 1'b1;
                                w_rc_next  = '0;
                            end else begin
                                w_rc_next = r_rc + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_rc_next    = '0;
                    end
                endcase
                // An accepted release overrides a repeat due on the same tick.
                if (w_acc_release) begin
                    w_state_next = ST_IDLE;
                    w_rc_next    = '0;
                    w_rpt_fire   = 1'b0;
                end
                w_press_next   = w_acc_press | w_rpt_fire;
                w_release_next = w_acc_release;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_rc      <= '0;
                    r_state   <= ST_IDLE;
                end else begin
                    r_cnt     <= w_cnt_next;
                    r_level   <= w_level_next;
                    r_press   <= w_press_next;
                    r_release <= w_release_next;
                    r_rc      <= w_rc_next;
                    r_state   <= w_state_next;
                end
            end

            assign btn_level[gi]   = r_level;
            assign btn_press[gi]   = r_press;
            assign btn_release[gi] = r_release;
        end
    endgenerate
endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Directed bench for btn_debounce_rpt: STABLE_TICKS=4, REPEAT_DELAY=10,
// REPEAT_RATE=3, tick every 5th clk (or tied high in the last step).
module tb_btn_debounce_rpt;
    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int n_cmp  = 0;
    int n_fail = 0;
    int phase  = 0;
    bit tick_hi = 1'b0;
    int tick_num = 0;
    int press_cnt [4] = '{default: 0};
    int rel_cnt [4] = '{default: 0};
    int last_press_tick [4] = '{default: 0};
    int last_rel_tick [4] = '{default: 0};

    btn_debounce_rpt #(
        .N_BTN       (4),
        .STABLE_TICKS(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick) tick_num <= tick_num + 1;
    end

    // Event log: pulse counts and the tick number at which each pulse appeared.
    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (btn_press[b]) begin
                press_cnt[b]       <= press_cnt[b] + 1;
                last_press_tick[b] <= tick_num;
            end
            if (btn_release[b]) begin
                rel_cnt[b]       <= rel_cnt[b] + 1;
                last_rel_tick[b] <= tick_num;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
        phase = (phase == 4) ? 0 : phase + 1;
        tick  = tick_hi | (phase == 4);
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = tick_num;
        while (tick_num - t0 < n) cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0 = press pulse, 1 = release pulse; n returns clk cycles waited.
    task automatic wait_ev(input int kind, input int b, input int limit, input string tag,
                           output int n);
        int s;
        int cur;
        s   = (kind == 0) ? press_cnt[b] : rel_cnt[b];
        cur = s;
        n   = 0;
        while (cur == s && n < limit) begin
            cyc();
            n++;
            cur = (kind == 0) ? press_cnt[b] : rel_cnt[b];
        end
        n_cmp++;
        assert (cur != s) else begin
            n_fail++;
            $error("FAIL %s: no pulse on bit %0d within %0d clk (count %0d, required > %0d)",
                   tag, b, limit, cur, s);
        end
        $display("[%0t] %s: %s bit%0d after %0d clk, tick %0d, press=%b release=%b level=%b",
                 $time, tag, (kind == 0) ? "press" : "release", b, n, tick_num,
                 btn_press, btn_release, btn_level);
    endtask

    initial begin
        int base;
        int acc;
        int n;
        int s;
        int rk [4] = '{10, 13, 16, 19};

        rst     = 1'b1;
        tick    = 1'b0;
        btn_raw = 4'h0;
        #1;
        rst     = 1'b0;
        btn_raw = 4'hF;

        // 1: held in reset with all buttons pressed
        for (int i = 0; i < 50; i++) begin
            cyc();
            chk("rst_hold_out", {20'd0, btn_level, btn_press, btn_release}, 32'd0);
        end
        rst = 1'b1;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(0, 0, 80, "rst_rel_press", n);
        chk("rst_rel_press_ticks", last_press_tick[0] - base, 4);
        chk("rst_rel_press_vec", btn_press, 4'hF);
        chk("rst_rel_level", btn_level, 4'hF);
        chk("rst_rel_no_release", btn_release, 4'h0);
        btn_raw = 4'h0;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(1, 0, 80, "all_release", n);
        chk("all_release_ticks", last_rel_tick[0] - base, 4);
        chk("all_release_vec", btn_release, 4'hF);
        chk("all_release_level", btn_level, 4'h0);
        chk("all_release_one_press", press_cnt[0], 1);

        // 2: clean press and release on bit 0
        btn_raw = 4'b0001;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(0, 0, 80, "clean_press", n);
        chk("clean_press_ticks", last_press_tick[0] - base, 4);
        chk("clean_press_vec", btn_press, 4'b0001);
        chk("clean_level", btn_level, 4'b0001);
        btn_raw = 4'b0000;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(1, 0, 80, "clean_release", n);
        chk("clean_release_ticks", last_rel_tick[0] - base, 4);
        chk("clean_release_level", btn_level, 4'b0000);

        // 3: bounce on bit 1 (high 2 ticks, low 1 tick, five times)
        s = press_cnt[1];
        for (int r = 0; r < 5; r++) begin
            btn_raw[1] = 1'b1;
            wait_ticks(2);
            btn_raw[1] = 1'b0;
            wait_ticks(1);
            chk("bounce_level", btn_level, 4'b0000);
        end
        chk("bounce_no_press", press_cnt[1], s);
        btn_raw[1] = 1'b1;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(0, 1, 80, "bounce_press", n);
        chk("bounce_press_ticks", last_press_tick[1] - base, 4);
        chk("bounce_press_vec", btn_press, 4'b0010);
        wait_ticks(5);
        chk("bounce_single_press", press_cnt[1], s + 1);
        btn_raw[1] = 1'b0;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(1, 1, 80, "bounce_release", n);
        chk("bounce_release_ticks", last_rel_tick[1] - base, 4);

        // 4: auto-repeat on bit 2; release timed to coincide with a due repeat
        btn_raw[2] = 1'b1;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(0, 2, 80, "rpt_accept", n);
        acc = last_press_tick[2];
        chk("rpt_accept_ticks", acc - base, 4);
        for (int k = 0; k < 4; k++) begin
            wait_ev(0, 2, 80, "rpt_pulse", n);
            chk("rpt_pulse_tick", last_press_tick[2] - acc, rk[k]);
            chk("rpt_pulse_vec", btn_press, 4'b0100);
        end
        while (tick_num - acc < 21) cyc();
        btn_raw[2] = 1'b0;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(0, 2, 80, "rpt_during_rel", n);
        chk("rpt_during_rel_tick", last_press_tick[2] - acc, 22);
        s = press_cnt[2];
        wait_ev(1, 2, 80, "rpt_release", n);
        chk("rpt_release_ticks", last_rel_tick[2] - base, 4);
        chk("rpt_release_wins", btn_press, 4'b0000);
        chk("rpt_release_level", btn_level, 4'b0000);
        wait_ticks(4);
        chk("rpt_stopped", press_cnt[2], s);

        // 5: asynchronous reset while bit 2 is repeating
        btn_raw[2] = 1'b1;
        cyc();
        cyc();
        wait_ev(0, 2, 80, "mid_accept", n);
        wait_ev(0, 2, 80, "mid_first_rpt", n);
        chk("mid_pre_rst_press", btn_press, 4'b0100);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_async", {24'd0, btn_level, btn_press}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mid_rst_hold", {20'd0, btn_level, btn_press, btn_release}, 32'd0);
        end
        rst = 1'b1;
        cyc();
        cyc();
        base = tick_num;
        wait_ev(0, 2, 80, "mid_fresh_press", n);
        acc = last_press_tick[2];
        chk("mid_fresh_ticks", acc - base, 4);
        wait_ev(0, 2, 80, "mid_fresh_rpt", n);
        chk("mid_fresh_rpt_ticks", last_press_tick[2] - acc, 10);
        btn_raw[2] = 1'b0;
        cyc();
        cyc();
        wait_ev(1, 2, 80, "mid_release", n);
        chk("mid_release_level", btn_level, 4'b0000);

        // 6: tick tied high, bits 0 and 3 together
        tick_hi = 1'b1;
        tick    = 1'b1;
        cyc();
        cyc();
        cyc();
        btn_raw = 4'b1001;
        wait_ev(0, 0, 20, "sim_press", n);
        chk("sim_press_clk", n, 6);
        chk("sim_press_vec", btn_press, 4'b1001);
        chk("sim_level", btn_level, 4'b1001);
        wait_ev(0, 0, 30, "sim_rpt", n);
        chk("sim_rpt_clk", n, 10);
        chk("sim_rpt_vec", btn_press, 4'b1001);
        btn_raw = 4'b0000;
        wait_ev(1, 0, 20, "sim_release", n);
        chk("sim_release_clk", n, 6);
        chk("sim_release_vec", btn_release, 4'b1001);
        chk("sim_release_level", btn_level, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
